seq_mul_unit: RTL and testbench
===============================

Name: seq_mul_unit

Overview:
- Iterative shift-and-add multiplier for the RV32M MUL/MULH/MULHSU/MULHU instructions in the EX stage.
- Holds a 2N-bit partial product and feeds the running high half plus the multiplicand into an N-bit ripple adder each cycle. The adder's N+1-bit sum (carry included) is consumed by the next shift.
- The hazard unit stalls the pipeline while busy=1.
- The final result is written back through the normal EX/MEM register on done.

Parameters:
N, 32, operand width in bits. Product width is 2N. The iteration counter is clog2(N)+1 bits.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE
funct  input  2  00 MUL (low N), 01 MULH (s×s high), 10 MULHSU (s×u high), 11 MULHU (u×u high)
a  input  N  rs1 operand
b  input  N  rs2 operand
flush  input  1  synchronous abort (branch mispredict / pipeline flush)
busy  output  1  high whenever state != IDLE
done  output  1  one-cycle pulse; result valid this cycle
result  output  N  selected half of the product; held until the next accepted start

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE; busy=0; done=0; result=0.
  - Accumulator, counter and sign flag cleared.
  - Reset asserted mid-operation discards the operation; no done is produced.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - When start=1 and flush=0, latch funct.
  - a_signed = (funct==01 or 10). b_signed = (funct==01).
  - Multiplicand = |a| if a_signed, else a. Multiplier = |b| if b_signed, else b. Magnitude is taken in two's complement, so |0x80000000| = 0x80000000 treated as unsigned.
  - neg = (a_signed & a[N-1]) XOR (b_signed & b[N-1]).
  - acc_hi=0; acc_lo=multiplier; count=0; go to CALC.
- CALC, one iteration per cycle:
  - If acc_lo[0]=1, sum = acc_hi + multiplicand (N+1 bits); else sum = {0, acc_hi}.
  - {acc_hi, acc_lo} <= {sum, acc_lo[N-1:1]}, i.e. the carry shifts into the MSB.
  - count++. After the Nth iteration, go to FIX.
- FIX:
  - If neg=1, the product is replaced by its 2N-bit two's complement.
  - result <= low N bits if funct==00, else high N bits.
  - Go to DONE.
- DONE: done=1 for exactly this cycle; go to IDLE.
- Latency: if start is accepted at edge E0, done is high in the cycle following edge E0+N+1. That is N+2 cycles from acceptance to result.
- Throughput: a new start is accepted no earlier than the edge that returns the block to IDLE.
- start while busy=1: ignored. Operands are not re-sampled; the in-flight operation is unaffected.
- flush=1 in any non-IDLE state: go to IDLE at the next edge. done is not asserted and result keeps its previous value.
- flush and start together in IDLE: flush wins; the request is dropped.
- result changes only on the FIX→DONE edge and on reset.
- Corner cases requiring no special logic:
  - A zero operand simply completes N iterations.
  - The MULH overflow case (most-negative × most-negative) gives a positive product.
  - RISC-V defines no exceptions for multiplication.

Test Plan:
- Basic MUL: reset, then start with funct=00, a=7, b=6 → done pulses exactly N+2 cycles after acceptance, result=42, busy high throughout, result=0 before completion.
- Signed extremes: funct=01, a=b=0x80000000 → result=0x40000000. funct=00 with the same operands → result=0x00000000.
- Unsigned and mixed sign: funct=11, a=b=0xFFFFFFFF → 0xFFFFFFFE. funct=10, a=0xFFFFFFFF (−1), b=0xFFFFFFFF (unsigned) → 0xFFFFFFFF. funct=00 with the same operands → 0x00000001.
- Start while busy: issue a second start with different operands at cycle 5 of a MUL 3×5 → ignored; result=15, only one done pulse.
- Flush: assert flush in cycle 10 of CALC → busy drops next cycle, no done, result still holds the prior value. A subsequent MUL 2×(−3) returns 0xFFFFFFFA.
- Async reset: drop rst_n mid-CALC between clock edges → busy, done and result go to 0 immediately. After release, a new MUL 9×9 completes correctly with result=81.

Source files
------------

// File: rtl/seq_mul_unit.sv
// Iterative shift-and-add multiplier for RV32M MUL/MULH/MULHSU/MULHU.
// Magnitudes are multiplied over N cycles, then the sign is restored in one fix-up cycle.
module seq_mul_unit #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [1:0]   funct,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         flush,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result
);

  localparam int CW = $clog2(N) + 1;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t          state_q;
  logic [N-1:0]    acc_hi_q, acc_lo_q, mcand_q, result_q;
  logic [CW-1:0]   cnt_q;
  logic            neg_q, done_q;
  logic [1:0]      funct_q;

  logic            a_signed_d, b_signed_d, a_neg_d, b_neg_d;
  logic [N-1:0]    mcand_d, mplier_d;
  logic [N:0]      sum_d;
  logic [2*N-1:0]  prod_d;

  // Operand conditioning for the request seen in IDLE, plus the per-iteration adder.
  always_comb begin
    a_signed_d = (funct == 2'b01) || (funct == 2'b10);
    b_signed_d = (funct == 2'b01);
    a_neg_d    = a_signed_d & a[N-1];
    b_neg_d    = b_signed_d & b[N-1];
    mcand_d    = a_neg_d ? -a : a;
    mplier_d   = b_neg_d ? -b : b;
    sum_d      = acc_lo_q[0] ? ({1'b0, acc_hi_q} + {1'b0, mcand_q}) : {1'b0, acc_hi_q};
    prod_d     = neg_q ? -{acc_hi_q, acc_lo_q} : {acc_hi_q, acc_lo_q};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      mcand_q  <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      done_q   <= 1'b0;
      funct_q  <= 2'b00;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start && !flush) begin
            funct_q  <= funct;
            mcand_q  <= mcand_d;
            acc_hi_q <= '0;
            acc_lo_q <= mplier_d;
            neg_q    <= a_neg_d ^ b_neg_d;
            cnt_q    <= '0;
            state_q  <= CALC;
          end
        end
        CALC: begin
          if (flush) begin
            state_q <= IDLE;
          end else begin
            // The adder carry becomes the new MSB as the accumulator shifts right.
            {acc_hi_q, acc_lo_q} <= {sum_d, acc_lo_q[N-1:1]};
            cnt_q <= cnt_q + CW'(1);
            if (cnt_q == CW'(N - 1)) state_q <= FIX;
          end
        end
        FIX: begin
          if (flush) begin
            state_q <= IDLE;
          end else begin
            result_q <= (funct_q == 2'b00) ? prod_d[N-1:0] : prod_d[2*N-1:N];
            done_q   <= 1'b1;
            state_q  <= DONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy   = (state_q != IDLE);
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_seq_mul_unit.sv
// Directed self-checking bench for seq_mul_unit.
module tb_seq_mul_unit;

  localparam int N = 32;

  logic         clk = 1'b0;
  logic         rst_n, start, flush, busy, done;
  logic [1:0]   funct;
  logic [N-1:0] a, b, result;

  int checkCount = 0;
  int passCount  = 0;

  seq_mul_unit #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .funct(funct), .a(a), .b(b),
    .flush(flush), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // Present a request at a falling edge so it is accepted at the following rising edge.
  task automatic applyStimulus(input logic [1:0] f, input logic [N-1:0] x, input logic [N-1:0] y);
    @(negedge clk);
    start = 1'b1; funct = f; a = x; b = y;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Count falling edges after acceptance until done, bounded so a dead DUT still terminates.
  task automatic waitDone(output int cycles, output logic busyOk);
    cycles = 0;
    busyOk = 1'b1;
    while (cycles < 100) begin
      @(negedge clk);
      cycles++;
      if (!busy) busyOk = 1'b0;
      if (done) break;
    end
  endtask

  task automatic countDones(input int span, output int pulses);
    pulses = 0;
    for (int i = 0; i < span; i++) begin
      @(negedge clk);
      if (done) pulses++;
    end
  endtask

  task automatic runOp(input string tag, input logic [1:0] f, input logic [N-1:0] x,
                       input logic [N-1:0] y, input logic [N-1:0] exp);
    int cyc;
    logic bOk;
    applyStimulus(f, x, y);
    waitDone(cyc, bOk);
    checkOutput({tag, "_done"}, {31'b0, done}, 32'd1);
    checkOutput({tag, "_result"}, result, exp);
  endtask

  initial begin
    int   cyc, pulses;
    logic bOk;
    rst_n = 1'b0; start = 1'b0; flush = 1'b0; funct = 2'b00; a = '0; b = '0;
    repeat (2) @(negedge clk);
    checkOutput("reset_busy", {31'b0, busy}, 32'd0);
    checkOutput("reset_done", {31'b0, done}, 32'd0);
    checkOutput("reset_result", result, 32'd0);
    rst_n = 1'b1;

    // Basic MUL 7*6 with latency and busy coverage.
    applyStimulus(2'b00, 32'd7, 32'd6);
    @(negedge clk);
    checkOutput("mul_result_before_done", result, 32'd0);
    checkOutput("mul_busy_after_accept", {31'b0, busy}, 32'd1);
    waitDone(cyc, bOk);
    cyc = cyc + 1;
    checkOutput("mul_latency", cyc, N + 2);
    checkOutput("mul_busy_throughout", {31'b0, bOk}, 32'd1);
    checkOutput("mul_done", {31'b0, done}, 32'd1);
    checkOutput("mul_result", result, 32'd42);
    checkOutput("mul_busy_in_done", {31'b0, busy}, 32'd1);
    @(negedge clk);
    checkOutput("mul_done_one_cycle", {31'b0, done}, 32'd0);
    checkOutput("mul_idle_after", {31'b0, busy}, 32'd0);

    // Signed, unsigned and mixed-sign extremes.
    runOp("mulh_minmin", 2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
    runOp("mul_minmin", 2'b00, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000);
    runOp("mulhu_ones", 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    runOp("mulhsu_ones", 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    runOp("mul_ones", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);
    runOp("mulh_neg_pos", 2'b01, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF);
    runOp("mul_zero", 2'b00, 32'd0, 32'h1234_5678, 32'd0);

    // Start while busy is ignored.
    applyStimulus(2'b00, 32'd3, 32'd5);
    repeat (4) @(negedge clk);
    start = 1'b1; funct = 2'b01; a = 32'd100; b = 32'd200;
    @(negedge clk);
    start = 1'b0;
    waitDone(cyc, bOk);
    checkOutput("busy_start_done", {31'b0, done}, 32'd1);
    checkOutput("busy_start_result", result, 32'd15);
    countDones(40, pulses);
    checkOutput("busy_start_single_done", pulses, 32'd0);

    // Flush mid-calculation.
    applyStimulus(2'b00, 32'd11, 32'd13);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    checkOutput("flush_busy_drop", {31'b0, busy}, 32'd0);
    countDones(40, pulses);
    checkOutput("flush_no_done", pulses, 32'd0);
    checkOutput("flush_result_held", result, 32'd15);

    // Flush together with start in IDLE drops the request.
    @(negedge clk);
    start = 1'b1; flush = 1'b1; funct = 2'b00; a = 32'd4; b = 32'd4;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    checkOutput("flush_start_dropped", {31'b0, busy}, 32'd0);

    runOp("mul_2_neg3", 2'b00, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFA);

    // Asynchronous reset between clock edges mid-operation.
    applyStimulus(2'b00, 32'd5, 32'd5);
    repeat (8) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("areset_busy", {31'b0, busy}, 32'd0);
    checkOutput("areset_done", {31'b0, done}, 32'd0);
    checkOutput("areset_result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    countDones(40, pulses);
    checkOutput("areset_no_done", pulses, 32'd0);
    runOp("mul_9_9", 2'b00, 32'd9, 32'd9, 32'd81);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
